// File: rtl/posit_pd_arbiter.sv
// posit_pd_arbiter: round-robin arbiter that feeds one shared posit-decoded
// consumer from NUM_REQ producers through a single registered output stage.
// Optional per-requester grant counters are built when POSIT_PD_ARB_STATS_EN
// is defined; without it there is no stat_grants port.

package posit_defines;
   typedef enum logic [0:0] {NORMAL = 1'b0, EXTENDED = 1'b1} pd_type;

   // Signed scale must hold +/-(n-2)*2^es plus the exponent field
   function automatic int unsigned get_scale_width(int unsigned n, int unsigned es, pd_type t);
      return unsigned'($clog2(n)) + es + 1 + ((t == EXTENDED) ? 1 : 0);
   endfunction

   // Fraction bits left after sign, minimum regime and exponent
   function automatic int unsigned get_fraction_width(int unsigned n, int unsigned es, pd_type t);
      return (t == EXTENDED) ? n : (n - es - 3);
   endfunction
endpackage

module posit_pd_arbiter #(
   parameter int unsigned          POSIT_WIDTH = 8,
   parameter int unsigned          POSIT_ES    = 0,
   parameter posit_defines::pd_type PD_TYPE    = posit_defines::NORMAL,
   parameter int unsigned          NUM_REQ     = 4,
   localparam int unsigned SCALE_W = posit_defines::get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
   localparam int unsigned FRAC_W  = posit_defines::get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
   localparam int unsigned REC_W   = SCALE_W + FRAC_W + 6,
   localparam int unsigned ID_W    = (NUM_REQ > 2) ? unsigned'($clog2(NUM_REQ)) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [NUM_REQ-1:0]       in_valid,
   output logic [NUM_REQ-1:0]       in_ready,
   input  logic [NUM_REQ*REC_W-1:0] in_rec,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [REC_W-1:0]         out_rec,
   output logic [ID_W-1:0]          out_id
`ifdef POSIT_PD_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]    stat_grants
`endif
);

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  win;
   logic [ID_W-1:0]  win_hi;
   logic [ID_W-1:0]  win_lo;
   logic [ID_W-1:0]  ptr_nxt;
   logic             found_hi;
   logic             found_lo;
   logic             can_load;
   logic             accept;
   logic [REC_W-1:0] win_rec;

   // Rotating priority: lowest valid index at or above ptr, else lowest valid overall
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            found_lo = 1'b1;
            win_lo   = ID_W'(i);
            if (ID_W'(i) >= ptr) begin
               found_hi = 1'b1;
               win_hi   = ID_W'(i);
            end
         end
      end
      win = found_hi ? win_hi : win_lo;
   end

   // Handshake qualification and winner record select
   always_comb begin
      can_load = ~out_valid | out_ready;
      accept   = rst_n & ~flush & can_load & found_lo;
      ptr_nxt  = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
      win_rec  = '0;
      in_ready = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (win == ID_W'(i)) begin
            win_rec     = in_rec[i*REC_W +: REC_W];
            in_ready[i] = accept;
         end
      end
   end

   // Output register and priority pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         out_valid <= 1'b0;
         out_rec   <= '0;
         out_id    <= '0;
      end else if (flush) begin
         ptr       <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         ptr       <= ptr_nxt;
         out_valid <= 1'b1;
         out_rec   <= win_rec;
         out_id    <= win;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef POSIT_PD_ARB_STATS_EN
   logic [NUM_REQ-1:0][15:0] grant_cnt;

   // Saturating per-requester grant counters, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (in_ready[i] && (grant_cnt[i] != 16'hFFFF)) begin
               grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
         end
      end
   end

   assign stat_grants = grant_cnt;
`endif

endmodule

// File: tb/tb_posit_pd_arbiter.sv
// Bench for posit_pd_arbiter (default parameters: 4 requesters, 15-bit records).
// Grant counter checks are built only when POSIT_PD_ARB_STATS_EN is defined.
module tb_posit_pd_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned REC_W = 15;
   localparam int unsigned ID_W  = 2;

   typedef struct {
      logic            rst;
      logic [N-1:0]    valid;
      logic            ordy;
      logic            fl;
      logic [N-1:0]    exp_rdy;
      logic            exp_ov;
      logic [ID_W-1:0] exp_id;
   } vec_t;

   logic                 clk;
   logic                 rst_n;
   logic                 flush;
   logic [N-1:0]         in_valid;
   logic [N-1:0]         in_ready;
   logic [N*REC_W-1:0]   in_rec;
   logic                 out_valid;
   logic                 out_ready;
   logic [REC_W-1:0]     out_rec;
   logic [ID_W-1:0]      out_id;
`ifdef POSIT_PD_ARB_STATS_EN
   logic [N*16-1:0]      stat_grants;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [REC_W-1:0] init_rec [N];
   logic [REC_W-1:0] cur_rec  [N];

   posit_pd_arbiter #(.NUM_REQ(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_rec     (in_rec),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rec    (out_rec),
      .out_id     (out_id)
`ifdef POSIT_PD_ARB_STATS_EN
      ,
      .stat_grants(stat_grants)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [N-1:0] va, input logic o,
                               input logic f, input logic [N-1:0] er, input logic ov,
                               input logic [ID_W-1:0] id);
      vec_t v;
      v.rst = r; v.valid = va; v.ordy = o; v.fl = f;
      v.exp_rdy = er; v.exp_ov = ov; v.exp_id = id;
      return v;
   endfunction

   task automatic drive_rec();
      for (int i = 0; i < int'(N); i++) in_rec[i*REC_W +: REC_W] = cur_rec[i];
   endtask

   initial begin
      vec_t             tbl[$];
      vec_t             v;
      logic [REC_W-1:0] exp_rec;
      logic [N-1:0]     prev_valid;
      logic [N-1:0]     prev_rdy;
      logic             prev_rst;
      logic [N-1:0]     seen;

      init_rec[0] = 15'h0A5C;
      init_rec[1] = 15'h5A13;
      init_rec[2] = {1'b0, 1'b1, 1'b0, 4'b1101, 5'b10110, 1'b0, 1'b0, 1'b1}; // scale -3, sticky
      init_rec[3] = 15'h7FFF;
      for (int i = 0; i < int'(N); i++) cur_rec[i] = init_rec[i];

      rst_n = 1'b0; flush = 1'b0; in_valid = '0; out_ready = 1'b0; in_rec = '0;
      exp_rec = '0; prev_valid = '0; prev_rdy = '0; prev_rst = 1'b1;

      //               rst  valid    ordy  fl   exp_rdy  ov    id
      tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0)); // reset, all valid
      tbl.push_back(mk(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0));
      for (int k = 0; k < 8; k++)                                         // round robin 0..3 twice
         tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 4'(1 << (k % 4)), 1'b1, ID_W'(k % 4)));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0));
      tbl.push_back(mk(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1)); // ptr -> 2
      tbl.push_back(mk(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1)); // drain, id held
      tbl.push_back(mk(1'b0, 4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3)); // 3, 1, 3
      tbl.push_back(mk(1'b0, 4'b1010, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1));
      tbl.push_back(mk(1'b0, 4'b1010, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3));
      tbl.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0));
      tbl.push_back(mk(1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2)); // load while empty
      for (int k = 0; k < 5; k++)                                         // downstream stall
         tbl.push_back(mk(1'b0, 4'b1100, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2));
      tbl.push_back(mk(1'b0, 4'b1100, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3)); // pop and load
      tbl.push_back(mk(1'b0, 4'b1110, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3)); // flush
      tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0)); // ptr was cleared
      tbl.push_back(mk(1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0));
      tbl.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1));

      for (int r = 0; r < tbl.size(); r++) begin
         v = tbl[r];
         rst_n = ~v.rst; in_valid = v.valid; out_ready = v.ordy; flush = v.fl;
         drive_rec();
         #1;
         chk($sformatf("in_ready row%0d", r), 64'(in_ready), 64'(v.exp_rdy));
         if (!v.rst && !prev_rst)
            chk($sformatf("producer_hold row%0d", r),
                64'(prev_valid & ~prev_rdy & ~v.valid), 64'(0));
         prev_valid = v.valid; prev_rdy = v.exp_rdy; prev_rst = v.rst;
         if (v.rst) begin
            exp_rec = '0;
         end else begin
            for (int i = 0; i < int'(N); i++) begin
               if (v.exp_rdy[i]) begin
                  exp_rec    = cur_rec[i];
                  cur_rec[i] = cur_rec[i] + 15'h0111;
               end
            end
         end
         @(posedge clk);
         #1;
         if (v.rst) for (int i = 0; i < int'(N); i++) cur_rec[i] = init_rec[i];
         chk($sformatf("out_valid row%0d", r), 64'(out_valid), 64'(v.exp_ov));
         chk($sformatf("out_id row%0d", r), 64'(out_id), 64'(v.exp_id));
         chk($sformatf("out_rec row%0d", r), 64'(out_rec), 64'(exp_rec));
      end

      // Fairness and full throughput: every window of 4 accepts covers all requesters
      rst_n = 1'b0; flush = 1'b0; in_valid = '0; out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 4'b1111;
      seen = '0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         chk($sformatf("tput out_valid c%0d", c), 64'(out_valid), 64'(1));
         seen[out_id] = 1'b1;
         if ((c % 4) == 3) begin
            chk($sformatf("fair window%0d", c / 4), 64'(seen), 64'(4'b1111));
            seen = '0;
         end
      end

`ifdef POSIT_PD_ARB_STATS_EN
      // Grant counters: flush does not clear, saturation at 16'hFFFF
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 4'b0100;
      repeat (3) @(posedge clk);
      #1;
      chk("stat req2 after 3", 64'(stat_grants[2*16 +: 16]), 64'(3));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("stat req2 after flush", 64'(stat_grants[2*16 +: 16]), 64'(3));
      repeat (69997) @(posedge clk);
      #1;
      chk("stat req2 saturated", 64'(stat_grants[2*16 +: 16]), 64'(16'hFFFF));
      chk("stat req0", 64'(stat_grants[0*16 +: 16]), 64'(0));
      chk("stat req1", 64'(stat_grants[1*16 +: 16]), 64'(0));
      chk("stat req3", 64'(stat_grants[3*16 +: 16]), 64'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
